// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller for the shared shifter unit.
//
// Sequence per request: LOAD (shifter loads its source), one or more SHIFT
// steps of at most STEP_MAX positions each, then DONE (pulses done and
// loads ALUOut). LUI is handled as a 16-bit left shift of the immediate.
//
// Build option:
//   ZERO_SHIFT_BYPASS_EN - when defined, a zero-distance request goes
//                          LOAD -> DONE with no SHIFT cycle. When undefined,
//                          one SHIFT cycle with shift_n=0 is issued.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   start           in   request pulse, accepted only in IDLE
//   op[1:0]         in   00 SLL, 01 SRL, 10 SRA, 11 LUI
//   shamt[4:0]      in   shift distance (ignored for LUI, forced to 16)
//   busy            out  high in every state except IDLE
//   done            out  one-cycle pulse in DONE
//   SHIFTER_control out  000 nop, 001 load, 010 left, 011 lsr, 100 asr
//   M_SHIFTER       out  shifter source: 0 register B, 1 immediate
//   shift_n[4:0]    out  distance of the current shift step
//   aluout_load     out  ALUOut write enable, high only in DONE
//   err_busy        out  sticky: start seen while busy; cleared by reset
module shift_sequencer #(
    parameter int unsigned STEP_MAX = 31,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] shamt,
    output logic       busy,
    output logic       done,
    output logic [2:0] SHIFTER_control,
    output logic       M_SHIFTER,
    output logic [4:0] shift_n,
    output logic       aluout_load,
    output logic       err_busy
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpLui = 2'b11;

    localparam logic [2:0] CtlNop  = 3'b000;
    localparam logic [2:0] CtlLoad = 3'b001;
    localparam logic [2:0] CtlLeft = 3'b010;
    localparam logic [2:0] CtlLsr  = 3'b011;
    localparam logic [2:0] CtlAsr  = 3'b100;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_d;

    logic             busy_d;
    logic             done_d;
    logic [2:0]       ctrl_d;
    logic             m_d;
    logic [4:0]       shift_n_d;

    // Distance of one step: the remainder, capped at STEP_MAX.
    function automatic logic [CNT_W-1:0] step_of(input logic [CNT_W-1:0] r);
        if (r > CNT_W'(STEP_MAX)) begin
            return CNT_W'(STEP_MAX);
        end
        return r;
    endfunction

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        err_d   = err_busy | (start && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    rem_d   = (op == OpLui) ? CNT_W'(16) : CNT_W'(shamt);
                    state_d = StLoad;
                end
            end
            StLoad: begin
`ifdef ZERO_SHIFT_BYPASS_EN
                state_d = (rem_q == '0) ? StDone : StShift;
`else
                state_d = StShift;
`endif
            end
            StShift: begin
                // Subtraction is bounded by rem_q, so it never wraps.
                rem_d   = rem_q - step_of(rem_q);
                state_d = (rem_d == '0) ? StDone : StShift;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they belong to.
    always_comb begin
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        m_d       = (state_d == StLoad) && (op_d == OpLui);
        shift_n_d = 5'd0;
        ctrl_d    = CtlNop;

        unique case (state_d)
            StLoad: begin
                ctrl_d = CtlLoad;
            end
            StShift: begin
                shift_n_d = 5'(step_of(rem_d));
                unique case (op_d)
                    OpSrl:   ctrl_d = CtlLsr;
                    OpSra:   ctrl_d = CtlAsr;
                    OpSll,
                    OpLui:   ctrl_d = CtlLeft;
                    default: ctrl_d = CtlLeft;
                endcase
            end
            default: begin
                ctrl_d = CtlNop;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            op_q            <= OpSll;
            rem_q           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            SHIFTER_control <= CtlNop;
            M_SHIFTER       <= 1'b0;
            shift_n         <= 5'd0;
            aluout_load     <= 1'b0;
            err_busy        <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            rem_q           <= rem_d;
            busy            <= busy_d;
            done            <= done_d;
            SHIFTER_control <= ctrl_d;
            M_SHIFTER       <= m_d;
            shift_n         <= shift_n_d;
            aluout_load     <= done_d;
            err_busy        <= err_d;
        end
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for the shared shift register unit (shifter) in the multicycle datapath. It accepts one shift request from the control unit and drives the shifter. The sequence is: load the source, issue one or more shift steps, then signal completion and request the ALUOut load. Shift amounts larger than STEP_MAX are split into several steps, so narrow shifter variants also work.

Parameters:
STEP_MAX, 31, largest shift distance issued in a single shift step (1..31)
CNT_W, 5, width of the remaining-distance counter (holds 0..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 LUI
shamt  input  5  requested shift distance; ignored for LUI (forced to 16)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE
SHIFTER_control  output  3  000 nop, 001 load, 010 left, 011 logical right, 100 arithmetic right
M_SHIFTER  output  1  shifter source select: 0 = register B, 1 = immediate (LUI)
shift_n  output  5  distance for the current shift step
aluout_load  output  1  ALUOut write enable; high only in DONE
err_busy  output  1  sticky flag; set when start arrives while busy, cleared by reset only

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (port named reset). All state and outputs are registered; the FSM is Moore, and outputs decode from the state registers.
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE, remaining=0
  - busy=0, done=0, SHIFTER_control=000, M_SHIFTER=0, shift_n=0, aluout_load=0, err_busy=0
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - All outputs at their reset values, except err_busy, which holds.
  - On start=1: latch op; remaining = (op==11) ? 16 : shamt; go to LOAD.
- LOAD (exactly 1 cycle):
  - SHIFTER_control=001; M_SHIFTER = (op_latched==11).
  - Go to SHIFT.
- SHIFT (1 cycle per step):
  - SHIFTER_control = 010 for SLL/LUI, 011 for SRL, 100 for SRA.
  - shift_n = min(remaining, STEP_MAX).
  - At the clock edge: remaining -= shift_n. If the new remaining is 0, go to DONE; otherwise stay in SHIFT.
- DONE (exactly 1 cycle):
  - SHIFTER_control=000, done=1, aluout_load=1, busy=1.
  - Go to IDLE.
- Latency from the edge that samples start to the first cycle with done=1: 2 + ceil(remaining/STEP_MAX) cycles. A zero distance counts as one step (see Optional Feature).
- Step count for amount A: ceil(A/STEP_MAX), minimum 1. The last step carries the remainder.
- start while busy (any state other than IDLE):
  - The request is ignored; the sequence in progress is unaffected.
  - err_busy is set to 1.
- start high in the DONE cycle: ignored. It is accepted only on a cycle spent in IDLE. Back-to-back requests therefore have at least one IDLE cycle between them.
- op and shamt are don't-care except on the cycle start is accepted.
- Counter arithmetic is unsigned CNT_W bits; it never wraps, because the subtraction is bounded by remaining.

Optional Feature:
ZERO_SHIFT_BYPASS_EN
- Defined: if remaining == 0 at acceptance (shamt=0, non-LUI), LOAD goes directly to DONE, skipping SHIFT. Latency is 2 cycles.
- Undefined: one SHIFT cycle is issued with shift_n=0. Latency is 3 cycles.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-SHIFT:
  - Stimulus: STEP_MAX=4, SLL shamt=20; assert reset=0 during the 2nd SHIFT cycle.
  - Required: all outputs drop asynchronously to 0 with no clock; IDLE after release.
- SLL, shamt=8, STEP_MAX=31:
  - Required sequence: LOAD (001, M_SHIFTER=0) -> one SHIFT (010, shift_n=8) -> DONE (done=1, aluout_load=1).
  - done appears 3 cycles after start.
- SRA, shamt=10, STEP_MAX=4:
  - Required: SHIFT steps with shift_n = 4, 4, 2, all with SHIFTER_control=100; done 5 cycles after start.
- LUI, shamt=7 (ignored):
  - Required: M_SHIFTER=1 in LOAD; one SHIFT step with 010 and shift_n=16.
- Busy collision:
  - Stimulus: SRL shamt=3 in progress, then start pulsed in the SHIFT cycle and again in the DONE cycle.
  - Required: the in-flight sequence is unchanged; err_busy=1 after the first pulse; no second sequence starts.
- Zero-distance request:
  - Stimulus: SRL shamt=0.
  - Required with ZERO_SHIFT_BYPASS_EN: no SHIFT state; done 2 cycles after start.
  - Required without it: one SHIFT cycle with 011 and shift_n=0; done 3 cycles after start.
